// File: rtl/axi_lite_interface_synch_if.sv
// AXI-Lite bus bundle (AW/W/B/AR/R) between a master and the register slave.
// Latency: none, wires only.
// Backpressure: plain valid/ready per channel, one beat per handshake.
interface axi_lite_interface_synch_if #(
   parameter int AXI_ADDR_WIDTH = 64,
   parameter int AXI_ID_WIDTH   = 10
);
   logic                      aw_valid_i;
   logic                      aw_ready_o;
   logic [AXI_ADDR_WIDTH-1:0] aw_addr_i;
   logic [AXI_ID_WIDTH-1:0]   aw_id_i;

   logic                      w_valid_i;
   logic                      w_ready_o;
   logic [63:0]               w_data_i;
   logic [7:0]                w_strb_i;

   logic                      b_valid_o;
   logic                      b_ready_i;
   logic [AXI_ID_WIDTH-1:0]   b_id_o;
   logic [1:0]                b_resp_o;

   logic                      ar_valid_i;
   logic                      ar_ready_o;
   logic [AXI_ADDR_WIDTH-1:0] ar_addr_i;
   logic [AXI_ID_WIDTH-1:0]   ar_id_i;

   logic                      r_valid_o;
   logic                      r_ready_i;
   logic [AXI_ID_WIDTH-1:0]   r_id_o;
   logic [63:0]               r_data_o;
   logic [1:0]                r_resp_o;
   logic                      r_last_o;

   modport slave (
      input  aw_valid_i, aw_addr_i, aw_id_i,
      output aw_ready_o,
      input  w_valid_i, w_data_i, w_strb_i,
      output w_ready_o,
      output b_valid_o, b_id_o, b_resp_o,
      input  b_ready_i,
      input  ar_valid_i, ar_addr_i, ar_id_i,
      output ar_ready_o,
      output r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o,
      input  r_ready_i
   );

   modport master (
      output aw_valid_i, aw_addr_i, aw_id_i,
      input  aw_ready_o,
      output w_valid_i, w_data_i, w_strb_i,
      input  w_ready_o,
      input  b_valid_o, b_id_o, b_resp_o,
      output b_ready_i,
      output ar_valid_i, ar_addr_i, ar_id_i,
      input  ar_ready_o,
      input  r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o,
      output r_ready_i
   );
endinterface

// File: rtl/axi_lite_interface_synch.sv
// AXI-Lite to single-port register-file bridge plus a 2-flop input synchronizer.
// Latency: AW->en 1 cycle, ->B 2 cycles; AR->en 1 cycle, ->R 2 cycles; a_i->z_o 2 edges.
// Backpressure: one transaction outstanding; B/R held until ready, AW/AR refused meanwhile.
module axi_lite_interface_synch #(
   parameter int AXI_ADDR_WIDTH = 64,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ID_WIDTH   = 10
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   axi_lite_interface_synch_if.slave axi,
   output logic [AXI_ADDR_WIDTH-1:0] address_o,
   output logic                      en_o,
   output logic                      we_o,
   output logic [63:0]               data_o,
   input  logic [63:0]               data_i,
   input  logic                      a_i,
   output logic                      z_o
);

   generate
      if (AXI_DATA_WIDTH != 64) begin : g_bad_data_width
         $fatal(1, "axi_lite_interface_synch: only AXI_DATA_WIDTH=64 is supported");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WRITE   = 3'd1,
      WRITE_B = 3'd2,
      READ    = 3'd3,
      READ_R  = 3'd4
   } state_t;

   state_t                    state_q;
   logic [AXI_ADDR_WIDTH-1:0] addr_q;
   logic [AXI_ID_WIDTH-1:0]   id_q;
   logic [63:0]               rdata_q;
   logic                      aw_rdy_q;
   logic                      w_rdy_q;
   logic                      b_vld_q;
   logic                      r_vld_q;
   logic                      sync_ff1_q;
   logic                      sync_ff2_q;
   logic                      wr_beat;
   logic                      rd_beat;

   // Byte strobes carry no meaning here: every write is a full 64-bit word.
   logic unused_strb;
   assign unused_strb = ^axi.w_strb_i;

   // Transaction FSM: latches address/ID, captures read data, keeps handshake flags registered.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         id_q     <= '0;
         rdata_q  <= '0;
         aw_rdy_q <= 1'b1;
         w_rdy_q  <= 1'b0;
         b_vld_q  <= 1'b0;
         r_vld_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (axi.aw_valid_i) begin
                  addr_q   <= axi.aw_addr_i;
                  id_q     <= axi.aw_id_i;
                  aw_rdy_q <= 1'b0;
                  w_rdy_q  <= 1'b1;
                  state_q  <= WRITE;
               end else if (axi.ar_valid_i) begin
                  addr_q   <= axi.ar_addr_i;
                  id_q     <= axi.ar_id_i;
                  aw_rdy_q <= 1'b0;
                  state_q  <= READ;
               end
            end
            WRITE: begin
               if (axi.w_valid_i) begin
                  w_rdy_q <= 1'b0;
                  b_vld_q <= 1'b1;
                  state_q <= WRITE_B;
               end
            end
            WRITE_B: begin
               if (axi.b_ready_i) begin
                  b_vld_q  <= 1'b0;
                  aw_rdy_q <= 1'b1;
                  state_q  <= IDLE;
               end
            end
            READ: begin
               rdata_q <= data_i;
               r_vld_q <= 1'b1;
               state_q <= READ_R;
            end
            READ_R: begin
               if (axi.r_ready_i) begin
                  r_vld_q  <= 1'b0;
                  aw_rdy_q <= 1'b1;
                  state_q  <= IDLE;
               end
            end
            default: begin
               state_q  <= IDLE;
               aw_rdy_q <= 1'b1;
               w_rdy_q  <= 1'b0;
               b_vld_q  <= 1'b0;
               r_vld_q  <= 1'b0;
            end
         endcase
      end
   end

   // Two-flop synchronizer for the asynchronous a_i input.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_ff1_q <= 1'b0;
         sync_ff2_q <= 1'b0;
      end else begin
         sync_ff1_q <= a_i;
         sync_ff2_q <= sync_ff1_q;
      end
   end

   // Register-port strobes follow the W beat directly, so they are decoded, not registered;
   // a reset in the same cycle suppresses them so an aborted transaction never touches the file.
   assign wr_beat = !rst_i && (state_q == WRITE) && axi.w_valid_i;
   assign rd_beat = !rst_i && (state_q == READ);

   assign en_o      = wr_beat | rd_beat;
   assign we_o      = wr_beat;
   assign data_o    = wr_beat ? axi.w_data_i : 64'd0;
   assign address_o = addr_q;
   assign z_o       = sync_ff2_q;

   // AW takes priority over a simultaneous AR.
   assign axi.aw_ready_o = aw_rdy_q;
   assign axi.ar_ready_o = aw_rdy_q & ~axi.aw_valid_i;
   assign axi.w_ready_o  = w_rdy_q;
   assign axi.b_valid_o  = b_vld_q;
   assign axi.b_id_o     = id_q;
   assign axi.b_resp_o   = 2'b00;
   assign axi.r_valid_o  = r_vld_q;
   assign axi.r_id_o     = id_q;
   assign axi.r_data_o   = rdata_q;
   assign axi.r_resp_o   = 2'b00;
   assign axi.r_last_o   = 1'b1;

endmodule

// File: tb/tb_axi_lite_interface_synch.sv
// Directed bench for axi_lite_interface_synch: reset, write, read, AW/AR priority,
// response backpressure, synchronizer and mid-transaction reset.
// Inputs change 1 ns after the rising edge; outputs are checked 1-2 ns after it.
module tb_axi_lite_interface_synch;
   localparam int AW = 64;
   localparam int IW = 10;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [AW-1:0] address_o;
   logic          en_o;
   logic          we_o;
   logic [63:0]   data_o;
   logic [63:0]   data_i;
   logic          a_i;
   logic          z_o;

   int total = 0;
   int bad   = 0;

   axi_lite_interface_synch_if #(.AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW)) bus ();

   axi_lite_interface_synch #(
      .AXI_ADDR_WIDTH(AW),
      .AXI_DATA_WIDTH(64),
      .AXI_ID_WIDTH(IW)
   ) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .axi       (bus),
      .address_o (address_o),
      .en_o      (en_o),
      .we_o      (we_o),
      .data_o    (data_o),
      .data_i    (data_i),
      .a_i       (a_i),
      .z_o       (z_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      bus.aw_valid_i = 0; bus.aw_addr_i = '0; bus.aw_id_i = '0;
      bus.w_valid_i  = 0; bus.w_data_i  = '0; bus.w_strb_i = '0;
      bus.b_ready_i  = 0;
      bus.ar_valid_i = 0; bus.ar_addr_i = '0; bus.ar_id_i = '0;
      bus.r_ready_i  = 0;
      data_i = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      a_i = 0;
      rst_i = 1;
      tick(); tick();
      rst_i = 0;
      #1;
      total++; if (bus.aw_ready_o !== 1'b1) begin bad++; $display("FAIL rst_aw_ready got=%b exp=1", bus.aw_ready_o); end
      total++; if (bus.ar_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ar_ready got=%b exp=1", bus.ar_ready_o); end
      total++; if (bus.w_ready_o !== 1'b0) begin bad++; $display("FAIL rst_w_ready got=%b exp=0", bus.w_ready_o); end
      total++; if (bus.b_valid_o !== 1'b0) begin bad++; $display("FAIL rst_b_valid got=%b exp=0", bus.b_valid_o); end
      total++; if (bus.r_valid_o !== 1'b0) begin bad++; $display("FAIL rst_r_valid got=%b exp=0", bus.r_valid_o); end
      total++; if (en_o !== 1'b0 || we_o !== 1'b0) begin bad++; $display("FAIL rst_en got en=%b we=%b exp 0/0", en_o, we_o); end
      total++; if (address_o !== 64'd0) begin bad++; $display("FAIL rst_addr got=%h exp=0", address_o); end
      total++; if (z_o !== 1'b0) begin bad++; $display("FAIL rst_z got=%b exp=0", z_o); end
   endtask

   task automatic test_write();
      bus.aw_valid_i = 1; bus.aw_addr_i = 64'h400; bus.aw_id_i = 10'd5;
      #1;
      total++; if (bus.aw_ready_o !== 1'b1 || bus.ar_ready_o !== 1'b0) begin bad++; $display("FAIL wr_aw_hs got aw=%b ar=%b exp 1/0", bus.aw_ready_o, bus.ar_ready_o); end
      tick();
      bus.aw_valid_i = 0; bus.aw_addr_i = 64'hFFFF;
      #1;
      total++; if (bus.w_ready_o !== 1'b1 || en_o !== 1'b0 || bus.aw_ready_o !== 1'b0) begin bad++; $display("FAIL wr_wait got wr=%b en=%b awr=%b exp 1/0/0", bus.w_ready_o, en_o, bus.aw_ready_o); end
      bus.w_valid_i = 1; bus.w_data_i = 64'hDEAD_BEEF_0000_0001; bus.w_strb_i = 8'h00;
      #1;
      total++; if (en_o !== 1'b1 || we_o !== 1'b1) begin bad++; $display("FAIL wr_pulse got en=%b we=%b exp 1/1", en_o, we_o); end
      total++; if (address_o !== 64'h400) begin bad++; $display("FAIL wr_addr got=%h exp=400", address_o); end
      total++; if (data_o !== 64'hDEAD_BEEF_0000_0001) begin bad++; $display("FAIL wr_data got=%h exp=deadbeef00000001", data_o); end
      tick();
      bus.w_valid_i = 0; bus.w_data_i = '0;
      #1;
      total++; if (bus.b_valid_o !== 1'b1 || bus.b_id_o !== 10'd5 || bus.b_resp_o !== 2'b00) begin bad++; $display("FAIL wr_b got v=%b id=%0d resp=%0d exp 1/5/0", bus.b_valid_o, bus.b_id_o, bus.b_resp_o); end
      total++; if (en_o !== 1'b0 || we_o !== 1'b0 || data_o !== 64'd0 || bus.w_ready_o !== 1'b0) begin bad++; $display("FAIL wr_after got en=%b we=%b d=%h wr=%b exp 0/0/0/0", en_o, we_o, data_o, bus.w_ready_o); end
      bus.b_ready_i = 1;
      tick();
      bus.b_ready_i = 0;
      #1;
      total++; if (bus.b_valid_o !== 1'b0 || bus.aw_ready_o !== 1'b1) begin bad++; $display("FAIL wr_done got bv=%b awr=%b exp 0/1", bus.b_valid_o, bus.aw_ready_o); end
   endtask

   task automatic test_read();
      bus.ar_valid_i = 1; bus.ar_addr_i = 64'hC00; bus.ar_id_i = 10'd3;
      #1;
      total++; if (bus.ar_ready_o !== 1'b1) begin bad++; $display("FAIL rd_ar_ready got=%b exp=1", bus.ar_ready_o); end
      tick();
      bus.ar_valid_i = 0; data_i = 64'h1234;
      #1;
      total++; if (en_o !== 1'b1 || we_o !== 1'b0 || address_o !== 64'hC00) begin bad++; $display("FAIL rd_pulse got en=%b we=%b a=%h exp 1/0/c00", en_o, we_o, address_o); end
      total++; if (bus.r_valid_o !== 1'b0 || data_o !== 64'd0) begin bad++; $display("FAIL rd_early got rv=%b d=%h exp 0/0", bus.r_valid_o, data_o); end
      tick();
      data_i = 64'hFFFF_FFFF;
      #1;
      total++; if (bus.r_valid_o !== 1'b1 || bus.r_data_o !== 64'h1234 || bus.r_id_o !== 10'd3) begin bad++; $display("FAIL rd_r got v=%b d=%h id=%0d exp 1/1234/3", bus.r_valid_o, bus.r_data_o, bus.r_id_o); end
      total++; if (bus.r_last_o !== 1'b1 || bus.r_resp_o !== 2'b00 || en_o !== 1'b0) begin bad++; $display("FAIL rd_r_attr got last=%b resp=%0d en=%b exp 1/0/0", bus.r_last_o, bus.r_resp_o, en_o); end
      bus.r_ready_i = 1;
      tick();
      bus.r_ready_i = 0; data_i = '0;
      #1;
      total++; if (bus.r_valid_o !== 1'b0 || bus.aw_ready_o !== 1'b1) begin bad++; $display("FAIL rd_done got rv=%b awr=%b exp 0/1", bus.r_valid_o, bus.aw_ready_o); end
   endtask

   task automatic test_simultaneous();
      bus.aw_valid_i = 1; bus.aw_addr_i = 64'h800; bus.aw_id_i = 10'd7;
      bus.ar_valid_i = 1; bus.ar_addr_i = 64'h900; bus.ar_id_i = 10'd9;
      #1;
      total++; if (bus.aw_ready_o !== 1'b1 || bus.ar_ready_o !== 1'b0) begin bad++; $display("FAIL sim_prio got aw=%b ar=%b exp 1/0", bus.aw_ready_o, bus.ar_ready_o); end
      tick();
      bus.aw_valid_i = 0;
      #1;
      total++; if (bus.w_ready_o !== 1'b1 || bus.ar_ready_o !== 1'b0 || address_o !== 64'h800) begin bad++; $display("FAIL sim_write got wr=%b ar=%b a=%h exp 1/0/800", bus.w_ready_o, bus.ar_ready_o, address_o); end
      bus.w_valid_i = 1; bus.w_data_i = 64'h55;
      tick();
      bus.w_valid_i = 0;
      #1;
      total++; if (bus.b_valid_o !== 1'b1 || bus.b_id_o !== 10'd7) begin bad++; $display("FAIL sim_b got v=%b id=%0d exp 1/7", bus.b_valid_o, bus.b_id_o); end
      bus.b_ready_i = 1;
      tick();
      bus.b_ready_i = 0;
      #1;
      total++; if (bus.ar_ready_o !== 1'b1) begin bad++; $display("FAIL sim_ar_after got=%b exp=1", bus.ar_ready_o); end
      tick();
      bus.ar_valid_i = 0; data_i = 64'hABC;
      #1;
      total++; if (en_o !== 1'b1 || we_o !== 1'b0 || address_o !== 64'h900) begin bad++; $display("FAIL sim_rd_pulse got en=%b we=%b a=%h exp 1/0/900", en_o, we_o, address_o); end
      tick();
      data_i = '0;
      #1;
      total++; if (bus.r_valid_o !== 1'b1 || bus.r_id_o !== 10'd9 || bus.r_data_o !== 64'hABC) begin bad++; $display("FAIL sim_r got v=%b id=%0d d=%h exp 1/9/abc", bus.r_valid_o, bus.r_id_o, bus.r_data_o); end
      bus.r_ready_i = 1;
      tick();
      bus.r_ready_i = 0;
   endtask

   task automatic test_backpressure();
      bus.aw_valid_i = 1; bus.aw_addr_i = 64'h100; bus.aw_id_i = 10'h2A;
      tick();
      bus.aw_valid_i = 0;
      bus.w_valid_i = 1; bus.w_data_i = 64'h77;
      tick();
      // Competing traffic while B is stalled must be ignored.
      bus.aw_valid_i = 1; bus.aw_addr_i = 64'h200; bus.aw_id_i = 10'd1;
      bus.ar_valid_i = 1; bus.ar_addr_i = 64'h300; bus.ar_id_i = 10'd2;
      for (int i = 0; i < 5; i++) begin
         #1;
         total++; if (bus.b_valid_o !== 1'b1 || bus.b_id_o !== 10'h2A || address_o !== 64'h100) begin bad++; $display("FAIL bp_b_hold[%0d] got v=%b id=%h a=%h exp 1/2a/100", i, bus.b_valid_o, bus.b_id_o, address_o); end
         total++; if (bus.aw_ready_o !== 1'b0 || bus.ar_ready_o !== 1'b0 || en_o !== 1'b0) begin bad++; $display("FAIL bp_b_block[%0d] got aw=%b ar=%b en=%b exp 0/0/0", i, bus.aw_ready_o, bus.ar_ready_o, en_o); end
         tick();
      end
      bus.aw_valid_i = 0; bus.ar_valid_i = 0; bus.w_valid_i = 0;
      bus.b_ready_i = 1;
      tick();
      bus.b_ready_i = 0;
      // Read with R stalled while the register file output keeps changing.
      bus.ar_valid_i = 1; bus.ar_addr_i = 64'h500; bus.ar_id_i = 10'd11;
      tick();
      bus.ar_valid_i = 0; data_i = 64'hCAFE;
      tick();
      bus.aw_valid_i = 1; bus.ar_valid_i = 1;
      for (int i = 0; i < 5; i++) begin
         data_i = 64'h1000 + 64'(i);
         #1;
         total++; if (bus.r_valid_o !== 1'b1 || bus.r_data_o !== 64'hCAFE || bus.r_id_o !== 10'd11) begin bad++; $display("FAIL bp_r_hold[%0d] got v=%b d=%h id=%0d exp 1/cafe/11", i, bus.r_valid_o, bus.r_data_o, bus.r_id_o); end
         total++; if (bus.aw_ready_o !== 1'b0 || bus.ar_ready_o !== 1'b0 || en_o !== 1'b0) begin bad++; $display("FAIL bp_r_block[%0d] got aw=%b ar=%b en=%b exp 0/0/0", i, bus.aw_ready_o, bus.ar_ready_o, en_o); end
         tick();
      end
      bus.aw_valid_i = 0; bus.ar_valid_i = 0; data_i = '0;
      bus.r_ready_i = 1;
      tick();
      bus.r_ready_i = 0;
      #1;
      total++; if (bus.r_valid_o !== 1'b0 || bus.aw_ready_o !== 1'b1) begin bad++; $display("FAIL bp_done got rv=%b awr=%b exp 0/1", bus.r_valid_o, bus.aw_ready_o); end
   endtask

   task automatic test_sync();
      a_i = 1;
      tick();
      total++; if (z_o !== 1'b0) begin bad++; $display("FAIL sync_edge1 got=%b exp=0", z_o); end
      tick();
      total++; if (z_o !== 1'b1) begin bad++; $display("FAIL sync_edge2 got=%b exp=1", z_o); end
      rst_i = 1;
      tick();
      rst_i = 0;
      total++; if (z_o !== 1'b0) begin bad++; $display("FAIL sync_rst got=%b exp=0", z_o); end
      a_i = 0;
      tick(); tick();
   endtask

   task automatic test_reset_mid();
      bus.aw_valid_i = 1; bus.aw_addr_i = 64'h300; bus.aw_id_i = 10'd4;
      tick();
      bus.aw_valid_i = 0;
      #1;
      total++; if (bus.w_ready_o !== 1'b1) begin bad++; $display("FAIL mid_in_write got=%b exp=1", bus.w_ready_o); end
      rst_i = 1;
      tick();
      rst_i = 0;
      #1;
      total++; if (bus.aw_ready_o !== 1'b1 || bus.w_ready_o !== 1'b0 || address_o !== 64'd0) begin bad++; $display("FAIL mid_idle got aw=%b wr=%b a=%h exp 1/0/0", bus.aw_ready_o, bus.w_ready_o, address_o); end
      bus.w_valid_i = 1; bus.w_data_i = 64'h99;
      #1;
      total++; if (en_o !== 1'b0 || we_o !== 1'b0 || data_o !== 64'd0) begin bad++; $display("FAIL mid_no_pulse got en=%b we=%b d=%h exp 0/0/0", en_o, we_o, data_o); end
      tick();
      bus.w_valid_i = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (bus.b_valid_o !== 1'b0 || en_o !== 1'b0) begin bad++; $display("FAIL mid_no_b[%0d] got bv=%b en=%b exp 0/0", i, bus.b_valid_o, en_o); end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_simultaneous();
      test_backpressure();
      test_sync();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
